// File: rtl/maze_rom_arbiter.sv
// Shares one single-port maze/sprite ROM between NUM_REQ requesters: fixed-priority requester 0 with a
// starvation guard, round-robin among the rest. Define ARB_STATS_EN to add per-requester grant/starvation counters.
module maze_rom_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int ROM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rdata_valid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_rd,
  input  logic [DATA_W-1:0]         rom_data,
  input  logic                      frame_start
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_cnt,
  output logic [7:0]                starve_hits
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_idx;
  logic [PTR_W-1:0]   hi_idx;
  logic [PTR_W-1:0]   lo_idx;
  logic               hi_found;
  logic               lo_found;
  logic [3:0]         starve_cnt;
  logic               others_pending;
  logic               mask_on;
  logic [ADDR_W-1:0]  gnt_addr;
  // Stage 0 lines up with rom_rd; the tail (stage ROM_LAT) lines up with valid rom_data.
  logic [NUM_REQ-1:0] id_pipe [ROM_LAT+1];

  assign others_pending = |req[NUM_REQ-1:1];
  assign mask_on        = others_pending && (starve_cnt == 4'(STARVE_MAX));

  // Round-robin search: first requester at or above rr_ptr, else the lowest one (wrap).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned j = 1; j < NUM_REQ; j++) begin
      if (req[j]) begin
        if (!hi_found && (PTR_W'(j) >= rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(j);
        end
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = PTR_W'(j);
        end
      end
    end
    rr_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    gnt = '0;
    if (Reset_n) begin
      if (req[0] && !mask_on) begin
        gnt[0] = 1'b1;
      end else if (lo_found) begin
        gnt[rr_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_addr = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr     <= PTR_W'(1);
      starve_cnt <= '0;
      rom_rd     <= 1'b0;
      rom_addr   <= '0;
      for (int unsigned k = 0; k <= ROM_LAT; k++) begin
        id_pipe[k] <= '0;
      end
    end else begin
      rom_rd     <= |gnt;
      id_pipe[0] <= gnt;
      for (int unsigned k = 1; k <= ROM_LAT; k++) begin
        id_pipe[k] <= id_pipe[k-1];
      end
      if (|gnt) begin
        rom_addr <= gnt_addr;
      end
      if ((|gnt) && !gnt[0]) begin
        rr_ptr <= (rr_idx == PTR_W'(NUM_REQ-1)) ? PTR_W'(1) : rr_idx + PTR_W'(1);
      end
      if (gnt[0] && others_pending) begin
        starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign rdata_valid = id_pipe[ROM_LAT];
  assign rdata       = rom_data;

`ifdef ARB_STATS_EN
  // frame_start clears every count; a grant on that same edge restarts its count at 1.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      grant_cnt   <= '0;
      starve_hits <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (frame_start) begin
          grant_cnt[i*16 +: 16] <= {15'd0, gnt[i]};
        end else if (gnt[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
      if (frame_start) begin
        starve_hits <= {7'd0, mask_on};
      end else if (mask_on && (starve_hits != 8'hFF)) begin
        starve_hits <= starve_hits + 8'd1;
      end
    end
  end
`else
  logic frame_start_unused;
  assign frame_start_unused = frame_start;
`endif

endmodule

// File: tb/tb_maze_rom_arbiter.sv
// Scoreboard bench for maze_rom_arbiter: a reference arbitration model predicts grants and ROM returns,
// and a separate monitor checks each rdata_valid pulse against the queued expectations.
module tb_maze_rom_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;
  localparam int ROM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic                      Clk = 1'b0;
  logic                      Reset_n = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*ADDR_W-1:0] addr = '0;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rdata_valid;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         rom_addr;
  logic                      rom_rd;
  logic [DATA_W-1:0]         rom_data;
  logic                      frame_start = 1'b0;
`ifdef ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     grant_cnt;
  logic [7:0]                starve_hits;
`endif

  maze_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .addr(addr), .gnt(gnt),
    .rdata_valid(rdata_valid), .rdata(rdata), .rom_addr(rom_addr), .rom_rd(rom_rd),
    .rom_data(rom_data), .frame_start(frame_start)
`ifdef ARB_STATS_EN
    , .grant_cnt(grant_cnt), .starve_hits(starve_hits)
`endif
  );

  always #5 Clk = ~Clk;

  // ROM model: data = low address byte inverted, ROM_LAT cycles after the read cycle.
  logic [DATA_W-1:0] rom_q [ROM_LAT];
  always @(posedge Clk) begin
    rom_q[0] <= rom_addr[7:0] ^ 8'hFF;
    for (int k = 1; k < ROM_LAT; k++) rom_q[k] <= rom_q[k-1];
  end
  assign rom_data = rom_q[ROM_LAT-1];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int               id;
    logic [DATA_W-1:0] data;
    int               due;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  int m_rr = 1;
  int m_starve = 0;
  logic [ADDR_W-1:0] m_rom_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'hFF;
  endfunction

  function automatic int model_pick(input logic [NUM_REQ-1:0] r);
    bit others;
    others = (r[NUM_REQ-1:1] != '0);
    if (r[0] && !(others && (m_starve == STARVE_MAX))) return 0;
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      int j;
      j = 1 + ((m_rr - 1 + k) % (NUM_REQ - 1));
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // One arbitration cycle; dir >= -1 adds a directed check of the grant (-1 = none expected).
  task automatic step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*ADDR_W-1:0] a,
                      input int dir, input logic fs);
    int w;
    bit others;
    exp_t e;
    req = r;
    addr = a;
    frame_start = fs;
    @(negedge Clk);
    w = model_pick(r);
    chk("gnt", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
    if (dir >= -1) chk("gnt_directed", 32'(gnt), (dir < 0) ? 32'd0 : (32'd1 << dir));
    others = (r[NUM_REQ-1:1] != '0);
    if (w >= 0) begin
      m_rom_addr = a[w*ADDR_W +: ADDR_W];
      e.id = w;
      e.data = rom_f(m_rom_addr);
      e.due = cyc + ROM_LAT + 1;
      sbq.push_back(e);
    end
    if (w == 0) begin
      m_starve = others ? m_starve + 1 : 0;
    end else begin
      m_starve = 0;
      if (w > 0) m_rr = (w % (NUM_REQ - 1)) + 1;
    end
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
    chk("rom_rd", 32'(rom_rd), (w >= 0) ? 32'd1 : 32'd0);
    chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
  endtask

  task automatic do_reset(input int n);
    req = '1;
    Reset_n = 1'b0;
    sbq.delete();
    m_rr = 1;
    m_starve = 0;
    m_rom_addr = '0;
    repeat (n) begin
      @(negedge Clk);
      chk("gnt_in_reset", 32'(gnt), 32'd0);
      chk("rom_rd_in_reset", 32'(rom_rd), 32'd0);
      chk("rom_addr_in_reset", 32'(rom_addr), 32'd0);
    end
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    req = '0;
  endtask

  exp_t mon_e;
  always @(negedge Clk) begin
    if (!Reset_n) begin
      chk("rdata_valid_in_reset", 32'(rdata_valid), 32'd0);
    end else if (rdata_valid != '0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata_valid_unexpected: actual %b required 0 (cycle %0d)", rdata_valid, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("rdata_valid", 32'(rdata_valid), 32'd1 << mon_e.id);
        chk("rdata", 32'(rdata), 32'(mon_e.data));
        chk("rdata_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mon_e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL rdata_valid_missing: actual 0 required id %0d (cycle %0d)", mon_e.id, cyc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  logic [NUM_REQ*ADDR_W-1:0] rnd_a;
  int dir_tab [12] = '{0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 3};
  int rr_tab  [6]  = '{1, 2, 3, 1, 2, 3};

  initial begin
    do_reset(3);

    // single requester 0, fixed address
    for (int i = 0; i < 4; i++) step(4'b0001, {36'h0, 12'h0A5}, 0, 1'b0);

    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      rnd_a = {16'($urandom()), $urandom()};
      step(4'b1110, rnd_a, rr_tab[i], 1'b0);
    end

    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      rnd_a = {16'($urandom()), $urandom()};
      step(4'b1111, rnd_a, dir_tab[i], 1'b0);
    end

    do_reset(2);
    rnd_a = {16'($urandom()), $urandom()};
    step(4'b0101, rnd_a, 0, 1'b0);
    step(4'b0100, rnd_a, 2, 1'b0);
    step(4'b0000, rnd_a, -1, 1'b0);
    repeat (ROM_LAT + 2) step(4'b0000, rnd_a, -1, 1'b0);

    // reset with two reads in flight: both must be dropped
    step(4'b0110, {$urandom(), 16'($urandom())}, 1, 1'b0);
    step(4'b0110, {$urandom(), 16'($urandom())}, 2, 1'b0);
    do_reset(3);
    step(4'b1111, {$urandom(), 16'($urandom())}, 0, 1'b0);
    step(4'b1110, {$urandom(), 16'($urandom())}, 1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      rnd_a = {16'($urandom()), $urandom()};
      step(4'($urandom_range(0, 15)), rnd_a, -2, ($urandom_range(0, 15) == 0));
    end

`ifdef ARB_STATS_EN
    do_reset(2);
    for (int i = 0; i < 5; i++) step(4'b0010, {$urandom(), 16'($urandom())}, 1, 1'b0);
    chk("grant_cnt1_before_frame", 32'(grant_cnt[31:16]), 32'd5);
    step(4'b0010, {$urandom(), 16'($urandom())}, 1, 1'b1);
    chk("grant_cnt1_after_frame", 32'(grant_cnt[31:16]), 32'd1);
    chk("grant_cnt0_after_frame", 32'(grant_cnt[15:0]), 32'd0);
    for (int i = 0; i < 65600; i++) step(4'b0010, rnd_a, -2, 1'b0);
    chk("grant_cnt1_saturated", 32'(grant_cnt[31:16]), 32'hFFFF);
`endif

    repeat (ROM_LAT + 3) step(4'b0000, rnd_a, -1, 1'b0);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
